// File: rtl/reg_fwd_unit.sv
// reg_fwd_unit
//   Operand forwarding and load-use interlock for the decode stage.
//   Each read port resolves its operand from (in priority order) x0, the
//   youngest matching forwarding source, its own hold buffer, or the
//   register file. A matching source whose data is not yet ready raises
//   a hazard; a small FSM counts consecutive stall cycles and raises a
//   sticky timeout when the count reaches STALL_MAX.
//
// Ports
//   clk, rst_n       clock, asynchronous active-low reset
//   flush_i          pipeline flush: clears FSM/counter and hold buffers
//   id_valid_i       valid instruction in decode
//   ext_stall_i      decode frozen by some other hazard source
//   src_wr_en_i      per-source write enable        [NUM_SRC]
//   src_wr_addr_i    per-source destination reg     [NUM_SRC*REG_AW]
//   src_wr_data_i    per-source write data          [NUM_SRC*DW]
//   src_rdy_i        per-source data valid (0 = load in flight)
//   rd_addr_i        decode read addresses          [NUM_RD*REG_AW]
//   rd_data_i        register file read data        [NUM_RD*DW]
//   rd_data_o        resolved operands              [NUM_RD*DW]
//   rd_addr_o        read address, 0 when forwarded/held/x0
//   stall_o          load-use interlock request (combinational)
//   timeout_o        sticky: stall count reached STALL_MAX
module reg_fwd_unit #(
  parameter int unsigned NUM_RD    = 2,
  parameter int unsigned NUM_SRC   = 2,
  parameter int unsigned REG_AW    = 5,
  parameter int unsigned DW        = 32,
  parameter int unsigned STALL_MAX = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush_i,
  input  logic                      id_valid_i,
  input  logic                      ext_stall_i,
  input  logic [NUM_SRC-1:0]        src_wr_en_i,
  input  logic [NUM_SRC*REG_AW-1:0] src_wr_addr_i,
  input  logic [NUM_SRC*DW-1:0]     src_wr_data_i,
  input  logic [NUM_SRC-1:0]        src_rdy_i,
  input  logic [NUM_RD*REG_AW-1:0]  rd_addr_i,
  input  logic [NUM_RD*DW-1:0]      rd_data_i,
  output logic [NUM_RD*DW-1:0]      rd_data_o,
  output logic [NUM_RD*REG_AW-1:0]  rd_addr_o,
  output logic                      stall_o,
  output logic                      timeout_o
);

  typedef enum logic {IDLE, STALL} state_t;

  state_t            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              timeout_q;

  logic [NUM_RD-1:0] hold_vld_q;
  logic [REG_AW-1:0] hold_addr_q [NUM_RD];
  logic [DW-1:0]     hold_data_q [NUM_RD];

  logic [NUM_RD-1:0] port_hz;
  logic [NUM_RD-1:0] port_live;
  logic [REG_AW-1:0] p_addr;
  logic              hit;
  logic              hz;
  logic              id_adv;

  // Operand selection. Outputs default to zero, which already covers the
  // x0 case and the forced-zero address for forwarded/held operands.
  always_comb begin
    rd_data_o = '0;
    rd_addr_o = '0;
    port_hz   = '0;
    port_live = '0;
    p_addr    = '0;
    hit       = 1'b0;
    for (int unsigned p = 0; p < NUM_RD; p++) begin
      p_addr = rd_addr_i[p*REG_AW +: REG_AW];
      hit    = (p_addr == '0);
      for (int unsigned s = 0; s < NUM_SRC; s++) begin
        if (!hit && src_wr_en_i[s] &&
            (src_wr_addr_i[s*REG_AW +: REG_AW] == p_addr)) begin
          hit                   = 1'b1;
          rd_data_o[p*DW +: DW] = src_wr_data_i[s*DW +: DW];
          port_hz[p]            = ~src_rdy_i[s];
          port_live[p]          = src_rdy_i[s];
        end
      end
      if (!hit && hold_vld_q[p] && (hold_addr_q[p] == p_addr)) begin
        hit                   = 1'b1;
        rd_data_o[p*DW +: DW] = hold_data_q[p];
      end
      if (!hit) begin
        rd_data_o[p*DW +: DW]         = rd_data_i[p*DW +: DW];
        rd_addr_o[p*REG_AW +: REG_AW] = p_addr;
      end
    end
  end

  assign hz        = id_valid_i & (|port_hz);
  assign stall_o   = hz;
  assign id_adv    = id_valid_i & ~hz & ~ext_stall_i;
  assign timeout_o = timeout_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (hz && !flush_i) begin
          state_d = STALL;
          cnt_d   = 8'd1;
        end else begin
          cnt_d   = '0;
        end
      end
      STALL: begin
        if (flush_i || !hz) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q != 8'(STALL_MAX)) begin
          cnt_d   = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_q | (cnt_d == 8'(STALL_MAX));
    end
  end

  // Address-mismatch clearing refers to the buffer's current contents; a
  // capture in the same cycle installs the new address, so only flush and
  // id_adv take precedence over capture (id_adv and capture are exclusive).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_vld_q <= '0;
      for (int unsigned p = 0; p < NUM_RD; p++) begin
        hold_addr_q[p] <= '0;
        hold_data_q[p] <= '0;
      end
    end else begin
      for (int unsigned p = 0; p < NUM_RD; p++) begin
        if (flush_i || id_adv) begin
          hold_vld_q[p] <= 1'b0;
        end else if (ext_stall_i && !hz && port_live[p]) begin
          hold_vld_q[p]  <= 1'b1;
          hold_addr_q[p] <= rd_addr_i[p*REG_AW +: REG_AW];
          hold_data_q[p] <= rd_data_o[p*DW +: DW];
        end else if (hold_vld_q[p] &&
                     (hold_addr_q[p] != rd_addr_i[p*REG_AW +: REG_AW])) begin
          hold_vld_q[p] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_reg_fwd_unit.sv
module tb_reg_fwd_unit;
  localparam int NRD  = 2;
  localparam int NSRC = 2;
  localparam int AW   = 5;
  localparam int DW   = 32;
  localparam int SM   = 8;

  logic                 clk = 1'b0;
  logic                 rst_n, flush, id_valid, ext_stall;
  logic [NSRC-1:0]      src_wr_en, src_rdy;
  logic [NSRC*AW-1:0]   src_wr_addr;
  logic [NSRC*DW-1:0]   src_wr_data;
  logic [NRD*AW-1:0]    rd_addr, rd_addr_o;
  logic [NRD*DW-1:0]    rd_data, rd_data_o;
  logic                 stall_o, timeout_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reg_fwd_unit #(.NUM_RD(NRD), .NUM_SRC(NSRC), .REG_AW(AW), .DW(DW), .STALL_MAX(SM)) dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush), .id_valid_i(id_valid),
    .ext_stall_i(ext_stall), .src_wr_en_i(src_wr_en), .src_wr_addr_i(src_wr_addr),
    .src_wr_data_i(src_wr_data), .src_rdy_i(src_rdy), .rd_addr_i(rd_addr),
    .rd_data_i(rd_data), .rd_data_o(rd_data_o), .rd_addr_o(rd_addr_o),
    .stall_o(stall_o), .timeout_o(timeout_o));

  // ---------------- reference model ----------------
  int              m_cnt;
  logic            m_to;
  logic            m_hv [NRD];
  logic [AW-1:0]   m_ha [NRD];
  logic [DW-1:0]   m_hd [NRD];
  logic [DW-1:0]   e_data [NRD];
  logic [AW-1:0]   e_addr [NRD];
  logic            e_live [NRD];
  logic            e_hz;

  function automatic void model_reset();
    m_cnt = 0;
    m_to  = 1'b0;
    for (int p = 0; p < NRD; p++) m_hv[p] = 1'b0;
  endfunction

  function automatic void model_comb();
    logic any;
    any = 1'b0;
    for (int p = 0; p < NRD; p++) begin
      logic [AW-1:0] a;
      int hitsrc;
      a         = rd_addr[p*AW +: AW];
      e_data[p] = rd_data[p*DW +: DW];
      e_addr[p] = a;
      e_live[p] = 1'b0;
      hitsrc    = -1;
      if (a == 0) begin
        e_data[p] = 0;
        e_addr[p] = 0;
      end else begin
        for (int s = 0; s < NSRC; s++)
          if (hitsrc < 0 && src_wr_en[s] && src_wr_addr[s*AW +: AW] == a) hitsrc = s;
        if (hitsrc >= 0) begin
          e_data[p] = src_wr_data[hitsrc*DW +: DW];
          e_addr[p] = 0;
          if (src_rdy[hitsrc]) e_live[p] = 1'b1;
          else any = 1'b1;
        end else if (m_hv[p] && m_ha[p] == a) begin
          e_data[p] = m_hd[p];
          e_addr[p] = 0;
        end
      end
    end
    e_hz = id_valid & any;
  endfunction

  function automatic void model_step();
    logic adv;
    adv = id_valid & ~e_hz & ~ext_stall;
    for (int p = 0; p < NRD; p++) begin
      if (flush || adv) m_hv[p] = 1'b0;
      else if (ext_stall && !e_hz && e_live[p]) begin
        m_hv[p] = 1'b1;
        m_ha[p] = rd_addr[p*AW +: AW];
        m_hd[p] = e_data[p];
      end else if (m_ha[p] != rd_addr[p*AW +: AW]) m_hv[p] = 1'b0;
    end
    // consecutive stalled-cycle count, saturating
    if (flush || !e_hz) m_cnt = 0;
    else if (m_cnt < SM) m_cnt = m_cnt + 1;
    if (m_cnt == SM) m_to = 1'b1;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic drive_idle();
    flush = 0; id_valid = 0; ext_stall = 0;
    src_wr_en = '0; src_rdy = '0; src_wr_addr = '0; src_wr_data = '0;
    rd_addr = '0; rd_data = '0;
  endtask

  task automatic set_src(input int s, input logic en, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic r);
    src_wr_en[s] = en;
    src_wr_addr[s*AW +: AW] = a;
    src_wr_data[s*DW +: DW] = d;
    src_rdy[s] = r;
  endtask

  task automatic set_rd(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d);
    rd_addr[p*AW +: AW] = a;
    rd_data[p*DW +: DW] = d;
  endtask

  function automatic logic [DW-1:0] dout(input int p);
    return rd_data_o[p*DW +: DW];
  endfunction

  function automatic logic [AW-1:0] aout(input int p);
    return rd_addr_o[p*AW +: AW];
  endfunction

  task automatic do_reset();
    drive_idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic next_edge();
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    drive_idle();
    rst_n = 1'b0;
    set_rd(0, 5'd9, 32'h99);
    #2;
    checks++; if (dout(0) !== 32'h99) begin errors++; $display("FAIL reset_pass_data got %h want %h", dout(0), 32'h99); end
    checks++; if (aout(0) !== 5'd9) begin errors++; $display("FAIL reset_pass_addr got %0d want 9", aout(0)); end
    checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", stall_o); end
    checks++; if (timeout_o !== 1'b0) begin errors++; $display("FAIL reset_timeout got %b want 0", timeout_o); end
    do_reset();
  endtask

  task automatic test_bypass_order();
    do_reset();
    id_valid = 1;
    set_src(0, 1, 5'd5, 32'hAAAA0000, 1);
    set_src(1, 1, 5'd5, 32'h11111111, 1);
    set_rd(0, 5'd5, 32'h5555);
    set_rd(1, 5'd9, 32'h99);
    @(negedge clk);
    checks++; if (dout(0) !== 32'hAAAA0000) begin errors++; $display("FAIL bypass_data got %h want AAAA0000", dout(0)); end
    checks++; if (aout(0) !== 5'd0) begin errors++; $display("FAIL bypass_addr got %0d want 0", aout(0)); end
    checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL bypass_stall got %b want 0", stall_o); end
    checks++; if (dout(1) !== 32'h99 || aout(1) !== 5'd9) begin errors++; $display("FAIL bypass_pass p1 got %h/%0d want 99/9", dout(1), aout(1)); end
    next_edge();
  endtask

  task automatic test_load_use();
    do_reset();
    id_valid = 1;
    set_src(0, 1, 5'd7, 32'h77, 0);
    set_rd(1, 5'd7, 32'h1);
    @(negedge clk);
    checks++; if (stall_o !== 1'b1) begin errors++; $display("FAIL loaduse_stall got %b want 1", stall_o); end
    next_edge();
    set_src(0, 0, 5'd0, 32'h0, 0);
    set_src(1, 1, 5'd7, 32'hCAFE, 1);
    @(negedge clk);
    checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL loaduse_release got %b want 0", stall_o); end
    checks++; if (dout(1) !== 32'hCAFE || aout(1) !== 5'd0) begin errors++; $display("FAIL loaduse_data got %h/%0d want cafe/0", dout(1), aout(1)); end
    next_edge();
    checks++; if (timeout_o !== 1'b0) begin errors++; $display("FAIL loaduse_timeout got %b want 0", timeout_o); end
    // counter must have restarted: 7 more stall cycles stay short of STALL_MAX
    set_src(1, 0, 5'd0, 32'h0, 0);
    set_src(0, 1, 5'd7, 32'h77, 0);
    repeat (SM - 1) next_edge();
    checks++; if (timeout_o !== 1'b0) begin errors++; $display("FAIL loaduse_cnt_restart got %b want 0", timeout_o); end
  endtask

  task automatic test_x0();
    do_reset();
    id_valid = 1;
    set_src(0, 1, 5'd0, 32'hFFFF, 0);
    set_rd(0, 5'd0, 32'h1234);
    @(negedge clk);
    checks++; if (dout(0) !== 32'h0 || aout(0) !== 5'd0) begin errors++; $display("FAIL x0_data got %h/%0d want 0/0", dout(0), aout(0)); end
    checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL x0_stall got %b want 0", stall_o); end
    next_edge();
  endtask

  task automatic test_hold();
    do_reset();
    id_valid = 1; ext_stall = 1;
    set_src(1, 1, 5'd3, 32'h12345678, 1);
    set_rd(0, 5'd3, 32'hDEAD);
    @(negedge clk);
    checks++; if (dout(0) !== 32'h12345678) begin errors++; $display("FAIL hold_fwd got %h want 12345678", dout(0)); end
    next_edge();
    set_src(1, 0, 5'd0, 32'h0, 0);
    @(negedge clk);
    checks++; if (dout(0) !== 32'h12345678 || aout(0) !== 5'd0) begin errors++; $display("FAIL hold_used got %h/%0d want 12345678/0", dout(0), aout(0)); end
    next_edge();
    ext_stall = 0;
    @(negedge clk);
    checks++; if (dout(0) !== 32'h12345678) begin errors++; $display("FAIL hold_before_adv got %h want 12345678", dout(0)); end
    next_edge();
    @(negedge clk);
    checks++; if (dout(0) !== 32'hDEAD || aout(0) !== 5'd3) begin errors++; $display("FAIL hold_cleared got %h/%0d want dead/3", dout(0), aout(0)); end
    next_edge();
  endtask

  task automatic test_timeout();
    do_reset();
    id_valid = 1;
    set_src(0, 1, 5'd7, 32'h77, 0);
    set_rd(0, 5'd7, 32'h0);
    for (int k = 0; k < SM; k++) begin
      @(negedge clk);
      checks++; if (timeout_o !== 1'b0 || stall_o !== 1'b1) begin errors++; $display("FAIL timeout_early cyc %0d got to=%b st=%b want 0/1", k, timeout_o, stall_o); end
      next_edge();
    end
    checks++; if (timeout_o !== 1'b1) begin errors++; $display("FAIL timeout_set got %b want 1", timeout_o); end
    set_src(0, 0, 5'd0, 32'h0, 0);
    repeat (3) next_edge();
    checks++; if (timeout_o !== 1'b1 || stall_o !== 1'b0) begin errors++; $display("FAIL timeout_sticky got to=%b st=%b want 1/0", timeout_o, stall_o); end
    do_reset();
    checks++; if (timeout_o !== 1'b0) begin errors++; $display("FAIL timeout_reset got %b want 0", timeout_o); end
  endtask

  // capture a hold for x4 on port 0, then start a load-use stall on port 1
  task automatic setup_hold_and_stall();
    do_reset();
    id_valid = 1; ext_stall = 1;
    set_src(0, 1, 5'd4, 32'h44, 1);
    set_rd(0, 5'd4, 32'hBAD);
    next_edge();
    set_src(0, 1, 5'd6, 32'h66, 0);
    set_rd(1, 5'd6, 32'h0);
  endtask

  task automatic test_flush_mid_stall();
    setup_hold_and_stall();
    @(negedge clk);
    checks++; if (dout(0) !== 32'h44 || stall_o !== 1'b1) begin errors++; $display("FAIL flush_pre got %h/%b want 44/1", dout(0), stall_o); end
    next_edge();
    flush = 1;
    @(negedge clk);
    checks++; if (stall_o !== 1'b1 || dout(0) !== 32'h44) begin errors++; $display("FAIL flush_comb got %b/%h want 1/44", stall_o, dout(0)); end
    next_edge();
    flush = 0;
    @(negedge clk);
    checks++; if (dout(0) !== 32'hBAD || aout(0) !== 5'd4) begin errors++; $display("FAIL flush_hold_clr got %h/%0d want bad/4", dout(0), aout(0)); end
    // counter back at zero after flush: SM-1 further stalls must not time out
    repeat (SM - 1) next_edge();
    checks++; if (timeout_o !== 1'b0) begin errors++; $display("FAIL flush_cnt_clr got %b want 0", timeout_o); end
  endtask

  task automatic test_reset_mid_stall();
    setup_hold_and_stall();
    repeat (SM - 1) next_edge();
    #2 rst_n = 1'b0;
    #1;
    checks++; if (dout(0) !== 32'hBAD || aout(0) !== 5'd4) begin errors++; $display("FAIL rst_async_hold got %h/%0d want bad/4", dout(0), aout(0)); end
    checks++; if (timeout_o !== 1'b0 || stall_o !== 1'b1) begin errors++; $display("FAIL rst_async_out got to=%b st=%b want 0/1", timeout_o, stall_o); end
    #2 rst_n = 1'b1;
    repeat (SM - 1) next_edge();
    checks++; if (timeout_o !== 1'b0) begin errors++; $display("FAIL rst_cnt_clr got %b want 0", timeout_o); end
  endtask

  task automatic test_random(input int n);
    do_reset();
    model_reset();
    for (int i = 0; i < n; i++) begin
      id_valid  = ($urandom_range(0, 9) < 8);
      ext_stall = ($urandom_range(0, 9) < 3);
      flush     = ($urandom_range(0, 19) == 0);
      for (int s = 0; s < NSRC; s++)
        set_src(s, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 3)), $urandom,
                ($urandom_range(0, 3) != 0));
      for (int p = 0; p < NRD; p++) begin
        if ($urandom_range(0, 9) < 3) set_rd(p, AW'($urandom_range(0, 3)), $urandom);
        else rd_data[p*DW +: DW] = $urandom;
      end
      model_comb();
      @(negedge clk);
      for (int p = 0; p < NRD; p++) begin
        checks++; if (dout(p) !== e_data[p]) begin errors++; $display("FAIL rand_data i%0d p%0d got %h want %h", i, p, dout(p), e_data[p]); end
        checks++; if (aout(p) !== e_addr[p]) begin errors++; $display("FAIL rand_addr i%0d p%0d got %0d want %0d", i, p, aout(p), e_addr[p]); end
      end
      checks++; if (stall_o !== e_hz) begin errors++; $display("FAIL rand_stall i%0d got %b want %b", i, stall_o, e_hz); end
      checks++; if (timeout_o !== m_to) begin errors++; $display("FAIL rand_timeout i%0d got %b want %b", i, timeout_o, m_to); end
      @(posedge clk);
      model_step();
      #1;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    drive_idle();
    test_reset();
    test_bypass_order();
    test_load_use();
    test_x0();
    test_hold();
    test_timeout();
    test_flush_mid_stall();
    test_reset_mid_stall();
    test_random(600);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
